// File: rtl/rvm_mem_bridge_pkg.sv
// rvm_mem_bridge_pkg: shared access-size codes, bridge state encodings,
// the captured-request record and the alignment rule used by the bridge.
package rvm_mem_bridge_pkg;

  // Access size codes carried on ctrl_req_size; 2'b11 is reserved.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bridge FSM state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Request as captured at acceptance; held for the whole transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
  } mem_req_t;

  // True for a reserved size or an access that crosses its natural alignment.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rvm_mem_bridge_if.sv
// rvm_mem_bridge_if: control-side request/response and memory-bus signals of
// the bridge. The master modport is the bridge's own view (it masters the
// memory bus and answers the control FSM); slave is the environment view.
interface rvm_mem_bridge_if #(
  parameter int XLEN = 32
);
  logic            ctrl_req_valid;
  logic            ctrl_req_ready;
  logic            ctrl_req_we;
  logic [XLEN-1:0] ctrl_req_addr;
  logic [1:0]      ctrl_req_size;
  logic            ctrl_req_sext;
  logic [XLEN-1:0] ctrl_req_wdata;
  logic            ctrl_rsp_valid;
  logic [XLEN-1:0] ctrl_rsp_rdata;
  logic            ctrl_rsp_error;

  logic            mem_req;
  logic            mem_gnt;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  modport master (
    input  ctrl_req_valid, ctrl_req_we, ctrl_req_addr, ctrl_req_size,
           ctrl_req_sext, ctrl_req_wdata,
    output ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata, ctrl_rsp_error,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    output ctrl_req_valid, ctrl_req_we, ctrl_req_addr, ctrl_req_size,
           ctrl_req_sext, ctrl_req_wdata,
    input  ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata, ctrl_rsp_error,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

endinterface

// File: rtl/rvm_mem_bridge_align.sv
// rvm_mem_bridge_align: combinational byte-lane logic for the bridge.
// Checks the incoming request for misalignment/reserved size, and for the
// captured request builds write strobes, lane-replicated write data and the
// extracted, extended load data.
module rvm_mem_bridge_align
  import rvm_mem_bridge_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_off,
  output logic        chk_bad,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_shr;

  // Lane steering for stores and extraction/extension for loads.
  always_comb begin
    chk_bad    = is_bad_access(chk_size, chk_off);
    rdata_shr  = rdata >> {off, 3'b000};
    wstrb      = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = 32'h0;
    case (size)
      SZ_B: begin
        wstrb      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sext & rdata_shr[7]}}, rdata_shr[7:0]};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sext & rdata_shr[15]}}, rdata_shr[15:0]};
      end
      SZ_W: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_shr;
      end
      default: begin
        wstrb      = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;
      end
    endcase
    if (!we) wstrb = 4'b0000;
  end

endmodule

// File: rtl/rvm_mem_bridge.sv
// rvm_mem_bridge: single-outstanding memory access stage between the core
// control FSM and the external request/grant/response memory bus.
// Optional bus watchdog enabled by defining RVM_MEM_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; bad requests skip straight to RESP
// ISSUE    | mem_req high, address/strobes/data held until mem_gnt
// WAIT     | granted, waiting for mem_rvalid
// RESP     | one-cycle ctrl_rsp_valid with captured rdata/error
module rvm_mem_bridge
  import rvm_mem_bridge_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              resetn,
  rvm_mem_bridge_if.master bus
);

  if (XLEN != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("rvm_mem_bridge: XLEN must be 32 and TIMEOUT_CYCLES in 1..65535");
  end

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  mem_req_t    req_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;
  logic        accept;
  logic        chk_bad;
  logic        timeout;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign accept = (state == ST_IDLE) && bus.ctrl_req_valid;

  rvm_mem_bridge_align u_align (
    .chk_size   (bus.ctrl_req_size),
    .chk_off    (bus.ctrl_req_addr[1:0]),
    .chk_bad    (chk_bad),
    .we         (req_q.we),
    .size       (req_q.size),
    .off        (req_q.addr[1:0]),
    .sext       (req_q.sext),
    .wdata      (req_q.wdata),
    .rdata      (bus.mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

`ifdef RVM_MEM_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  logic [TW-1:0] tmo_cnt;

  // Down-counter loaded on entry to ISSUE; terminal count after TIMEOUT_CYCLES bus cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (accept && !chk_bad) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if ((state == ST_ISSUE || state == ST_WAIT) && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign timeout = (state == ST_ISSUE || state == ST_WAIT) && (tmo_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; a real grant/response wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.ctrl_req_valid) state_nxt = chk_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (bus.mem_gnt) state_nxt = ST_WAIT;
                else if (timeout) state_nxt = ST_RESP;
      ST_WAIT:  if (bus.mem_rvalid || timeout) state_nxt = ST_RESP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Request capture and response data/error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q       <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.ctrl_req_valid) begin
          req_q <= '{we:    bus.ctrl_req_we,
                     addr:  bus.ctrl_req_addr,
                     size:  bus.ctrl_req_size,
                     sext:  bus.ctrl_req_sext,
                     wdata: bus.ctrl_req_wdata};
          rsp_rdata_q <= 32'h0;
          rsp_error_q <= chk_bad;
        end
        ST_ISSUE: if (!bus.mem_gnt && timeout) rsp_error_q <= 1'b1;
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            rsp_error_q <= bus.mem_err;
            rsp_rdata_q <= (bus.mem_err || req_q.we) ? 32'h0 : lane_rdata;
          end else if (timeout) begin
            rsp_error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ctrl_req_ready = (state == ST_IDLE);
  assign bus.ctrl_rsp_valid = (state == ST_RESP);
  assign bus.ctrl_rsp_rdata = rsp_rdata_q;
  assign bus.ctrl_rsp_error = rsp_error_q;
  assign bus.mem_req        = (state == ST_ISSUE);
  assign bus.mem_we         = req_q.we;
  assign bus.mem_addr       = {req_q.addr[31:2], 2'b00};
  assign bus.mem_wstrb      = lane_wstrb;
  assign bus.mem_wdata      = lane_wdata;

endmodule

// File: tb/tb_rvm_mem_bridge.sv
// tb_rvm_mem_bridge: directed vectors for the memory bridge with hand-computed
// expected bus fields and responses.
module tb_rvm_mem_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  rvm_mem_bridge_if bus ();

  rvm_mem_bridge #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.ctrl_req_valid = 1'b0;
    bus.ctrl_req_we    = 1'b0;
    bus.ctrl_req_addr  = 32'h0;
    bus.ctrl_req_size  = 2'b00;
    bus.ctrl_req_sext  = 1'b0;
    bus.ctrl_req_wdata = 32'h0;
    bus.mem_gnt        = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = 32'h0;
    bus.mem_err        = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic sext, input logic [31:0] wdata);
    bus.ctrl_req_valid = 1'b1;
    bus.ctrl_req_we    = we;
    bus.ctrl_req_addr  = addr;
    bus.ctrl_req_size  = size;
    bus.ctrl_req_sext  = sext;
    bus.ctrl_req_wdata = wdata;
    check("ready_before_accept", bus.ctrl_req_ready, 1);
    tick;
    bus.ctrl_req_valid = 1'b0;
  endtask

  task automatic run_bus(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sext, input logic [31:0] wdata,
                         input int gnt_delay, input logic [31:0] bus_rdata, input logic bus_err,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
    send(we, addr, size, sext, wdata);
    for (int i = 0; i <= gnt_delay; i++) begin
      check({tag, "/mem_req"}, bus.mem_req, 1);
      check({tag, "/mem_addr"}, bus.mem_addr, exp_maddr);
      check({tag, "/mem_we"}, bus.mem_we, we);
      check({tag, "/mem_wstrb"}, bus.mem_wstrb, exp_strb);
      if (we) check({tag, "/mem_wdata"}, bus.mem_wdata, exp_wdata);
      check({tag, "/busy_ready"}, bus.ctrl_req_ready, 0);
      if (i == gnt_delay) bus.mem_gnt = 1'b1;
      tick;
    end
    bus.mem_gnt = 1'b0;
    check({tag, "/req_drop"}, bus.mem_req, 0);
    check({tag, "/no_early_rsp"}, bus.ctrl_rsp_valid, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = bus_rdata;
    bus.mem_err    = bus_err;
    tick;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_err    = 1'b0;
    check({tag, "/rsp_valid"}, bus.ctrl_rsp_valid, 1);
    check({tag, "/rsp_rdata"}, bus.ctrl_rsp_rdata, exp_rdata);
    check({tag, "/rsp_error"}, bus.ctrl_rsp_error, exp_err);
    tick;
    check({tag, "/rsp_pulse"}, bus.ctrl_rsp_valid, 0);
    check({tag, "/ready_after"}, bus.ctrl_req_ready, 1);
  endtask

  task automatic run_reject(input string tag, input logic [31:0] addr, input logic [1:0] size);
    send(1'b0, addr, size, 1'b1, 32'hFFFF_FFFF);
    check({tag, "/no_mem_req"}, bus.mem_req, 0);
    check({tag, "/rsp_valid"}, bus.ctrl_rsp_valid, 1);
    check({tag, "/rsp_error"}, bus.ctrl_rsp_error, 1);
    check({tag, "/rsp_rdata"}, bus.ctrl_rsp_rdata, 0);
    tick;
    check({tag, "/rsp_pulse"}, bus.ctrl_rsp_valid, 0);
    check({tag, "/no_mem_req2"}, bus.mem_req, 0);
    check({tag, "/ready_after"}, bus.ctrl_req_ready, 1);
  endtask

  initial begin
    idle_inputs();
    #3;
    check("rst/ready", bus.ctrl_req_ready, 1);
    check("rst/mem_req", bus.mem_req, 0);
    check("rst/rsp_valid", bus.ctrl_rsp_valid, 0);
    check("rst/rsp_rdata", bus.ctrl_rsp_rdata, 0);
    check("rst/rsp_error", bus.ctrl_rsp_error, 0);
    check("rst/mem_addr", bus.mem_addr, 0);
    check("rst/mem_wstrb", bus.mem_wstrb, 0);
    check("rst/mem_wdata", bus.mem_wdata, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick;

    //       tag    we    addr          sz     sx    wdata          gd rdata          err   exp_rdata      eerr  maddr          strb     exp_wdata
    run_bus("lw",   1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("lb_s", 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0,         0, 32'h8012_3456, 1'b0, 32'hFFFF_FF80, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("lb_u", 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0,         0, 32'h8012_3456, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("lbu1", 1'b0, 32'h0000_0101, 2'b00, 1'b0, 32'h0,         1, 32'h0000_C300, 1'b0, 32'h0000_00C3, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("lh_s", 1'b0, 32'h0000_0102, 2'b01, 1'b1, 32'h0,         0, 32'h8001_5555, 1'b0, 32'hFFFF_8001, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("lh_p", 1'b0, 32'h0000_0100, 2'b01, 1'b1, 32'h0,         0, 32'h1234_7FFF, 1'b0, 32'h0000_7FFF, 1'b0, 32'h0000_0100, 4'b0000, 32'h0);
    run_bus("sh",   1'b1, 32'h0000_0202, 2'b01, 1'b0, 32'hABCD_1234, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 32'h0000_0200, 4'b1100, 32'h1234_1234);
    run_bus("sb",   1'b1, 32'h0000_0301, 2'b00, 1'b0, 32'h0000_00AB, 0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0300, 4'b0010, 32'hABAB_ABAB);
    run_bus("sw",   1'b1, 32'h0000_0400, 2'b10, 1'b0, 32'hCAFE_F00D, 2, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
    run_bus("lwerr",1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0,         5, 32'h1234_5678, 1'b1, 32'h0,         1'b1, 32'h0000_0500, 4'b0000, 32'h0);

    run_reject("mis_w1", 32'h0000_0101, 2'b10);
    run_reject("mis_w2", 32'h0000_0102, 2'b10);
    run_reject("mis_h",  32'h0000_0103, 2'b01);
    run_reject("rsv_sz", 32'h0000_0100, 2'b11);

    // Reset while the request is on the bus.
    send(1'b0, 32'h0000_0600, 2'b10, 1'b0, 32'h0);
    check("rst_issue/req_before", bus.mem_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst_issue/mem_req", bus.mem_req, 0);
    check("rst_issue/ready", bus.ctrl_req_ready, 1);
    check("rst_issue/mem_addr", bus.mem_addr, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick;

    // Reset while waiting for the response; a stray rvalid must be ignored.
    send(1'b0, 32'h0000_0700, 2'b10, 1'b0, 32'h0);
    bus.mem_gnt = 1'b1;
    tick;
    bus.mem_gnt = 1'b0;
    check("rst_wait/in_wait", bus.ctrl_req_ready, 0);
    #2 resetn = 1'b0;
    #1;
    check("rst_wait/ready", bus.ctrl_req_ready, 1);
    check("rst_wait/mem_req", bus.mem_req, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    tick;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("rst_wait/no_rsp", bus.ctrl_rsp_valid, 0);
      check("rst_wait/idle", bus.ctrl_req_ready, 1);
      tick;
    end

    run_bus("lw_after_rst", 1'b0, 32'h0000_0800, 2'b10, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0,
            32'h0BAD_F00D, 1'b0, 32'h0000_0800, 4'b0000, 32'h0);

`ifdef RVM_MEM_TIMEOUT_EN
    send(1'b0, 32'h0000_0900, 2'b10, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("tmo/mem_req", bus.mem_req, 1);
      tick;
    end
    check("tmo/rsp_valid", bus.ctrl_rsp_valid, 1);
    check("tmo/rsp_error", bus.ctrl_rsp_error, 1);
    check("tmo/mem_req_drop", bus.mem_req, 0);
    tick;
    check("tmo/ready", bus.ctrl_req_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
